// File: rtl/multicycle_control.sv
// multicycle_control: main control FSM for a multicycle MIPS-style datapath.
// Ports: clock/reset (sync, active-high); Opcode/Funct from the IR;
//   datapath strobes and mux selects, ALUOpOut, State_out (state code), Illegal pulse.
// All outputs are registered alongside the state, so they are glitch-free and
// always correspond to the state currently reported on State_out.
module multicycle_control #(
  parameter int unsigned MEM_WAIT = 2  // memory read wait cycles, 0..15
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] Opcode,
  input  logic [5:0] Funct,
  output logic       PCWriteCond,
  output logic       PCWrite,
  output logic       IorD,
  output logic       MemReadWrite,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic       AluSrcA,
  output logic       RegWrite,
  output logic       RegDst,
  output logic [1:0] PCSource,
  output logic [1:0] AluSrcB,
  output logic [2:0] ALUOpOut,
  output logic [3:0] State_out,
  output logic       Illegal
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_LW_WB     = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ILLEGAL   = 4'd10
  } state_t;

  localparam logic [2:0] ALU_LOAD = 3'd0;
  localparam logic [2:0] ALU_ADD  = 3'd1;
  localparam logic [2:0] ALU_SUB  = 3'd2;
  localparam logic [2:0] ALU_AND  = 3'd3;
  localparam logic [2:0] ALU_XOR  = 3'd6;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  // Count value on the last cycle of FETCH / MEM_READ.
  localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT);

  typedef struct packed {
    logic       pc_write_cond;
    logic       pc_write;
    logic       i_or_d;
    logic       mem_rd_wr;
    logic       mem_to_reg;
    logic       ir_write;
    logic       alu_src_a;
    logic       reg_write;
    logic       reg_dst;
    logic [1:0] pc_source;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       illegal;
  } ctl_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] alu_hold_q, alu_hold_d;
  ctl_t       ctl_q, ctl_d;

  // Unsupported Funct codes map to LOAD so a bad R-type drives no ALU op.
  function automatic logic [2:0] funct_alu(input logic [5:0] f);
    case (f)
      6'h20:   return ALU_ADD;
      6'h22:   return ALU_SUB;
      6'h24:   return ALU_AND;
      6'h26:   return ALU_XOR;
      default: return ALU_LOAD;
    endcase
  endfunction

  function automatic logic funct_ok(input logic [5:0] f);
    return (f == 6'h20) || (f == 6'h22) || (f == 6'h24) || (f == 6'h26);
  endfunction

  // Output decode for a given state; last flags the final FETCH cycle.
  function automatic ctl_t state_ctl(input state_t st, input logic last,
                                     input logic [2:0] r_alu);
    ctl_t c;
    c = '0;
    case (st)
      S_FETCH: begin
        c.alu_src_b = 2'b01;
        c.alu_op    = ALU_ADD;
        c.ir_write  = last;
        c.pc_write  = last;
      end
      S_DECODE: begin
        c.alu_src_b = 2'b11;
        c.alu_op    = ALU_ADD;
      end
      S_MEM_ADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
        c.alu_op    = ALU_ADD;
      end
      S_MEM_READ: c.i_or_d = 1'b1;
      S_LW_WB: begin
        c.mem_to_reg = 1'b1;
        c.reg_write  = 1'b1;
      end
      S_MEM_WRITE: begin
        c.i_or_d    = 1'b1;
        c.mem_rd_wr = 1'b1;
      end
      S_R_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = r_alu;
      end
      S_R_WB: begin
        c.reg_dst   = 1'b1;
        c.reg_write = 1'b1;
        c.alu_src_a = 1'b1;
        c.alu_op    = r_alu;
      end
      S_BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_op        = ALU_SUB;
        c.pc_write_cond = 1'b1;
        c.pc_source     = 2'b01;
      end
      S_JUMP: begin
        c.pc_write  = 1'b1;
        c.pc_source = 2'b10;
      end
      S_ILLEGAL: c.illegal = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    alu_hold_d = alu_hold_q;
    case (state_q)
      S_FETCH: begin
        if (cnt_q == WAIT_LAST) state_d = S_DECODE;
        else                    cnt_d   = cnt_q + 4'd1;
      end
      S_DECODE: begin
        case (Opcode)
          OP_RTYPE:      state_d = S_R_EXEC;
          OP_LW, OP_SW:  state_d = S_MEM_ADDR;
          OP_BEQ:        state_d = S_BRANCH;
          OP_J:          state_d = S_JUMP;
          default:       state_d = S_ILLEGAL;
        endcase
      end
      S_MEM_ADDR: begin
        if (Opcode == OP_LW) begin
          state_d = S_MEM_READ;
          cnt_d   = 4'd0;
        end else begin
          state_d = S_MEM_WRITE;
        end
      end
      S_MEM_READ: begin
        if (cnt_q == WAIT_LAST) state_d = S_LW_WB;
        else                    cnt_d   = cnt_q + 4'd1;
      end
      S_R_EXEC: begin
        if (funct_ok(Funct)) begin
          state_d    = S_R_WB;
          alu_hold_d = funct_alu(Funct);  // frozen for R_WB
        end else begin
          state_d = S_ILLEGAL;
        end
      end
      default: begin
        // Single-cycle states and unused codes 11..15 all return to FETCH.
        state_d = S_FETCH;
        cnt_d   = 4'd0;
      end
    endcase

    // R_EXEC shows the ALU op of the current Funct; R_WB uses the held copy.
    ctl_d = state_ctl(state_d, cnt_d == WAIT_LAST,
                      (state_d == S_R_EXEC) ? funct_alu(Funct) : alu_hold_d);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_FETCH;
      cnt_q      <= 4'd0;
      alu_hold_q <= ALU_LOAD;
      // First FETCH cycle after reset never strobes PC/IR, even with MEM_WAIT=0.
      ctl_q      <= state_ctl(S_FETCH, 1'b0, ALU_LOAD);
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      alu_hold_q <= alu_hold_d;
      ctl_q      <= ctl_d;
    end
  end

  assign PCWriteCond  = ctl_q.pc_write_cond;
  assign PCWrite      = ctl_q.pc_write;
  assign IorD         = ctl_q.i_or_d;
  assign MemReadWrite = ctl_q.mem_rd_wr;
  assign MemtoReg     = ctl_q.mem_to_reg;
  assign IRWrite      = ctl_q.ir_write;
  assign AluSrcA      = ctl_q.alu_src_a;
  assign RegWrite     = ctl_q.reg_write;
  assign RegDst       = ctl_q.reg_dst;
  assign PCSource     = ctl_q.pc_source;
  assign AluSrcB      = ctl_q.alu_src_b;
  assign ALUOpOut     = ctl_q.alu_op;
  assign State_out    = state_q;
  assign Illegal      = ctl_q.illegal;

endmodule

// File: tb/tb_multicycle_control.sv
// Testbench for multicycle_control: three instances (MEM_WAIT = 2, 0, 15),
// each driven through directed instruction sequences while the others sit in reset.
module tb_multicycle_control;

  typedef struct packed {
    logic [3:0] st;
    logic       pcwc, pcw, iord, mrw, mtr, irw, asa, rw, rd;
    logic [1:0] pcs, asb;
    logic [2:0] alu;
    logic       ill;
  } obs_t;

  logic       clock;
  logic       rst [0:2];
  logic [5:0] opcode, funct;
  logic [3:0] so [0:2];
  logic       pcwc [0:2], pcw [0:2], iord [0:2], mrw [0:2], mtr [0:2];
  logic       irw [0:2], asa [0:2], rw [0:2], rd [0:2], ill [0:2];
  logic [1:0] pcs [0:2], asb [0:2];
  logic [2:0] alu [0:2];
  int         sel;
  obs_t       cur;

  int total = 0;
  int bad   = 0;
  obs_t  exp_q [$];
  string tag_q [$];

  multicycle_control #(.MEM_WAIT(2)) dut_a (
    .clock(clock), .reset(rst[0]), .Opcode(opcode), .Funct(funct),
    .PCWriteCond(pcwc[0]), .PCWrite(pcw[0]), .IorD(iord[0]), .MemReadWrite(mrw[0]),
    .MemtoReg(mtr[0]), .IRWrite(irw[0]), .AluSrcA(asa[0]), .RegWrite(rw[0]),
    .RegDst(rd[0]), .PCSource(pcs[0]), .AluSrcB(asb[0]), .ALUOpOut(alu[0]),
    .State_out(so[0]), .Illegal(ill[0]));

  multicycle_control #(.MEM_WAIT(0)) dut_b (
    .clock(clock), .reset(rst[1]), .Opcode(opcode), .Funct(funct),
    .PCWriteCond(pcwc[1]), .PCWrite(pcw[1]), .IorD(iord[1]), .MemReadWrite(mrw[1]),
    .MemtoReg(mtr[1]), .IRWrite(irw[1]), .AluSrcA(asa[1]), .RegWrite(rw[1]),
    .RegDst(rd[1]), .PCSource(pcs[1]), .AluSrcB(asb[1]), .ALUOpOut(alu[1]),
    .State_out(so[1]), .Illegal(ill[1]));

  multicycle_control #(.MEM_WAIT(15)) dut_c (
    .clock(clock), .reset(rst[2]), .Opcode(opcode), .Funct(funct),
    .PCWriteCond(pcwc[2]), .PCWrite(pcw[2]), .IorD(iord[2]), .MemReadWrite(mrw[2]),
    .MemtoReg(mtr[2]), .IRWrite(irw[2]), .AluSrcA(asa[2]), .RegWrite(rw[2]),
    .RegDst(rd[2]), .PCSource(pcs[2]), .AluSrcB(asb[2]), .ALUOpOut(alu[2]),
    .State_out(so[2]), .Illegal(ill[2]));

  always_comb begin
    cur = {so[sel], pcwc[sel], pcw[sel], iord[sel], mrw[sel], mtr[sel], irw[sel],
           asa[sel], rw[sel], rd[sel], pcs[sel], asb[sel], alu[sel], ill[sel]};
  end

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Expected outputs of one state, straight from the per-state output table.
  function automatic obs_t ev(input logic [3:0] st, input logic last,
                              input logic [2:0] a);
    obs_t e;
    e = '0;
    e.st = st;
    case (st)
      4'd0:  begin e.asb = 2'b01; e.alu = 3'd1; e.irw = last; e.pcw = last; end
      4'd1:  begin e.asb = 2'b11; e.alu = 3'd1; end
      4'd2:  begin e.asa = 1'b1; e.asb = 2'b10; e.alu = 3'd1; end
      4'd3:  e.iord = 1'b1;
      4'd4:  begin e.mtr = 1'b1; e.rw = 1'b1; end
      4'd5:  begin e.iord = 1'b1; e.mrw = 1'b1; end
      4'd6:  begin e.asa = 1'b1; e.alu = a; end
      4'd7:  begin e.rd = 1'b1; e.rw = 1'b1; e.asa = 1'b1; e.alu = a; end
      4'd8:  begin e.asa = 1'b1; e.alu = 3'd2; e.pcwc = 1'b1; e.pcs = 2'b01; end
      4'd9:  begin e.pcw = 1'b1; e.pcs = 2'b10; end
      4'd10: e.ill = 1'b1;
      default: e = '0;
    endcase
    return e;
  endfunction

  task automatic check(input string tag, input logic [20:0] o, input logic [20:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic push(input string tag, input obs_t e);
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  // n non-final FETCH cycles followed by the final (strobing) one.
  task automatic push_fetch(input string tag, input int n);
    for (int i = 0; i < n; i++) push(tag, ev(4'd0, 1'b0, 3'd0));
    push({tag, "_last"}, ev(4'd0, 1'b1, 3'd0));
  endtask

  // One observation per clock, #1 after the edge, until the queue is empty.
  task automatic drain();
    obs_t  e;
    string t;
    while (exp_q.size() > 0) begin
      @(posedge clock);
      #1;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check(t, cur, e);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [5:0] fn [3];
    logic [2:0] fa [3];
    fn[0] = 6'h20; fa[0] = 3'd1;
    fn[1] = 6'h24; fa[1] = 3'd3;
    fn[2] = 6'h26; fa[2] = 3'd6;

    rst[0] = 1'b1; rst[1] = 1'b1; rst[2] = 1'b1;
    opcode = 6'h23; funct = 6'h00; sel = 0;

    // ---- MEM_WAIT=2: reset state, then lw 0,0,0,1,2,3,3,3,4
    push("a_reset", ev(4'd0, 1'b0, 3'd0));
    drain();
    rst[0] = 1'b0;
    push_fetch("a_lw_fetch", 1);
    push("a_lw_decode", ev(4'd1, 1'b0, 3'd0));
    push("a_lw_addr", ev(4'd2, 1'b0, 3'd0));
    for (int i = 0; i < 3; i++) push("a_lw_read", ev(4'd3, 1'b0, 3'd0));
    push("a_lw_wb", ev(4'd4, 1'b0, 3'd0));
    drain();

    // R-type SUB: 0,0,0,1,6,7
    opcode = 6'h00; funct = 6'h22;
    push_fetch("a_sub_fetch", 2);
    push("a_sub_decode", ev(4'd1, 1'b0, 3'd0));
    push("a_sub_exec", ev(4'd6, 1'b0, 3'd2));
    push("a_sub_wb", ev(4'd7, 1'b0, 3'd2));
    drain();
    // Funct changing while in R_WB must not disturb ALUOpOut.
    funct = 6'h3F;
    #2;
    check("a_sub_wb_hold", {18'd0, alu[0]}, {18'd0, 3'd2});

    // Bad Funct: 6 then 10
    push_fetch("a_badfn_fetch", 2);
    push("a_badfn_decode", ev(4'd1, 1'b0, 3'd0));
    push("a_badfn_exec", ev(4'd6, 1'b0, 3'd0));
    push("a_badfn_illegal", ev(4'd10, 1'b0, 3'd0));
    drain();

    // Bad opcode: DECODE -> ILLEGAL
    opcode = 6'h3F; funct = 6'h20;
    push_fetch("a_badop_fetch", 2);
    push("a_badop_decode", ev(4'd1, 1'b0, 3'd0));
    push("a_badop_illegal", ev(4'd10, 1'b0, 3'd0));
    drain();

    // Remaining R-type ALU mappings
    opcode = 6'h00;
    for (int k = 0; k < 3; k++) begin
      funct = fn[k];
      push_fetch("a_r_fetch", 2);
      push("a_r_decode", ev(4'd1, 1'b0, 3'd0));
      push("a_r_exec", ev(4'd6, 1'b0, fa[k]));
      push("a_r_wb", ev(4'd7, 1'b0, fa[k]));
      drain();
    end

    // Reset in the second MEM_READ cycle, then a full 3-cycle FETCH
    opcode = 6'h23;
    push_fetch("a_rst_fetch", 2);
    push("a_rst_decode", ev(4'd1, 1'b0, 3'd0));
    push("a_rst_addr", ev(4'd2, 1'b0, 3'd0));
    push("a_rst_read", ev(4'd3, 1'b0, 3'd0));
    push("a_rst_read", ev(4'd3, 1'b0, 3'd0));
    drain();
    rst[0] = 1'b1;
    push("a_rst_hit", ev(4'd0, 1'b0, 3'd0));
    drain();
    rst[0] = 1'b0;
    push_fetch("a_rst_refetch", 1);
    push("a_rst_decode2", ev(4'd1, 1'b0, 3'd0));
    push("a_rst_addr2", ev(4'd2, 1'b0, 3'd0));
    for (int i = 0; i < 3; i++) push("a_rst_read2", ev(4'd3, 1'b0, 3'd0));
    push("a_rst_wb", ev(4'd4, 1'b0, 3'd0));
    drain();
    rst[0] = 1'b1;

    // ---- MEM_WAIT=0: sw 0,1,2,5 then beq 0,1,8 then lw 0,1,2,3,4
    sel = 1; opcode = 6'h2B;
    push("b_reset", ev(4'd0, 1'b0, 3'd0));
    drain();
    rst[1] = 1'b0;
    push("b_sw_decode", ev(4'd1, 1'b0, 3'd0));
    push("b_sw_addr", ev(4'd2, 1'b0, 3'd0));
    push("b_sw_write", ev(4'd5, 1'b0, 3'd0));
    drain();
    opcode = 6'h04;
    push_fetch("b_beq_fetch", 0);
    push("b_beq_decode", ev(4'd1, 1'b0, 3'd0));
    push("b_beq_branch", ev(4'd8, 1'b0, 3'd0));
    drain();
    opcode = 6'h23;
    push_fetch("b_lw_fetch", 0);
    push("b_lw_decode", ev(4'd1, 1'b0, 3'd0));
    push("b_lw_addr", ev(4'd2, 1'b0, 3'd0));
    push("b_lw_read", ev(4'd3, 1'b0, 3'd0));
    push("b_lw_wb", ev(4'd4, 1'b0, 3'd0));
    drain();
    rst[1] = 1'b1;

    // ---- MEM_WAIT=15: 16-cycle FETCH, then jump
    sel = 2; opcode = 6'h02;
    push("c_reset", ev(4'd0, 1'b0, 3'd0));
    drain();
    rst[2] = 1'b0;
    push_fetch("c_fetch", 14);
    push("c_decode", ev(4'd1, 1'b0, 3'd0));
    push("c_jump", ev(4'd9, 1'b0, 3'd0));
    push("c_refetch", ev(4'd0, 1'b0, 3'd0));
    drain();
    rst[2] = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
